// File: rtl/voice_allocator.sv
// Polyphony scheduler: assigns note-on/note-off events to NVOICES adsr voices, stealing when full.
// Optional statistics outputs (steal_count, orphan_off_count) enabled by defining VOICE_ALLOC_STATS_EN.
module voice_allocator #(
    parameter int NVOICES = 4,
    parameter int NOTE_W  = 7,
    parameter int AGE_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      ev_valid,
    output logic                      ev_ready,
    input  logic                      ev_on,
    input  logic [NOTE_W-1:0]         ev_note,
    input  logic [NVOICES-1:0]        voice_active,
    output logic [NVOICES-1:0]        trig,
    output logic [NVOICES*NOTE_W-1:0] voice_note,
    output logic                      steal
`ifdef VOICE_ALLOC_STATS_EN
    ,
    output logic [15:0]               steal_count,
    output logic [15:0]               orphan_off_count
`endif
);

    localparam int IW = (NVOICES > 1) ? $clog2(NVOICES) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

    typedef enum logic [1:0] {V_FREE, V_HELD, V_REL, V_STEAL} vstate_t;

    vstate_t           vstate [NVOICES];
    logic [AGE_W-1:0]  age    [NVOICES];
    logic [NOTE_W-1:0] note   [NVOICES];

    logic              ev_pend;
    logic              ev_on_r;
    logic [NOTE_W-1:0] ev_note_r;

    // Candidate search results
    logic              on_match_found, free_found, rel_found, held_found;
    logic [IW-1:0]     on_match_idx, free_idx, rel_idx, held_idx;
    logic [AGE_W-1:0]  rel_age, held_age;
    logic              off_held_found, off_steal_found;
    logic [IW-1:0]     off_held_idx, off_steal_idx;

    // Decision applied at the end of the decide cycle
    logic              dec_hit;
    logic [IW-1:0]     dec_idx;
    vstate_t           dec_state;
    logic              dec_load;
    logic              dec_age_clr;
    logic              dec_steal;
    logic              dec_orphan;

    assign ev_ready = ~ev_pend;

    always_comb begin
        on_match_found  = 1'b0; on_match_idx  = '0;
        free_found      = 1'b0; free_idx      = '0;
        rel_found       = 1'b0; rel_idx       = '0; rel_age  = '0;
        held_found      = 1'b0; held_idx      = '0; held_age = '0;
        off_held_found  = 1'b0; off_held_idx  = '0;
        off_steal_found = 1'b0; off_steal_idx = '0;
        for (int i = 0; i < NVOICES; i++) begin
            if ((vstate[i] == V_HELD || vstate[i] == V_STEAL) && note[i] == ev_note_r && !on_match_found) begin
                on_match_found = 1'b1;
                on_match_idx   = IW'(i);
            end
            if (vstate[i] == V_FREE && !free_found) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
            // Strict compare keeps the lowest index on age ties
            if (vstate[i] == V_REL && (!rel_found || age[i] > rel_age)) begin
                rel_found = 1'b1;
                rel_idx   = IW'(i);
                rel_age   = age[i];
            end
            if (vstate[i] == V_HELD && (!held_found || age[i] > held_age)) begin
                held_found = 1'b1;
                held_idx   = IW'(i);
                held_age   = age[i];
            end
            if (vstate[i] == V_HELD && note[i] == ev_note_r && !off_held_found) begin
                off_held_found = 1'b1;
                off_held_idx   = IW'(i);
            end
            if (vstate[i] == V_STEAL && note[i] == ev_note_r && !off_steal_found) begin
                off_steal_found = 1'b1;
                off_steal_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        dec_hit     = 1'b0;
        dec_idx     = '0;
        dec_state   = V_FREE;
        dec_load    = 1'b0;
        dec_age_clr = 1'b0;
        dec_steal   = 1'b0;
        dec_orphan  = 1'b0;
        if (ev_pend) begin
            if (ev_on_r) begin
                if (on_match_found) begin
                    dec_hit = 1'b1; dec_idx = on_match_idx; dec_state = V_STEAL; dec_age_clr = 1'b1;
                end else if (free_found) begin
                    dec_hit = 1'b1; dec_idx = free_idx; dec_state = V_HELD;
                    dec_load = 1'b1; dec_age_clr = 1'b1;
                end else if (rel_found) begin
                    dec_hit = 1'b1; dec_idx = rel_idx; dec_state = V_STEAL;
                    dec_load = 1'b1; dec_age_clr = 1'b1;
                end else if (held_found) begin
                    dec_hit = 1'b1; dec_idx = held_idx; dec_state = V_STEAL;
                    dec_load = 1'b1; dec_age_clr = 1'b1; dec_steal = 1'b1;
                end
            end else begin
                if (off_held_found) begin
                    dec_hit = 1'b1; dec_idx = off_held_idx; dec_state = V_REL;
                end else if (off_steal_found) begin
                    dec_hit = 1'b1; dec_idx = off_steal_idx; dec_state = V_REL;
                end else begin
                    dec_orphan = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ev_pend   <= 1'b0;
            ev_on_r   <= 1'b0;
            ev_note_r <= '0;
            steal     <= 1'b0;
        end else begin
            steal <= dec_steal;
            if (ev_valid && ev_ready) begin
                ev_pend   <= 1'b1;
                ev_on_r   <= ev_on;
                ev_note_r <= ev_note;
            end else begin
                ev_pend <= 1'b0;
            end
        end
    end

    // NOTE: the per-voice arrays are small flop banks, not RAM, so they take the async reset like any state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NVOICES; i++) begin
                vstate[i] <= V_FREE;
                age[i]    <= '0;
                note[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < NVOICES; i++) begin
                if (dec_hit && dec_idx == IW'(i)) begin
                    vstate[i] <= dec_state;
                    if (dec_load)
                        note[i] <= ev_note_r;
                end else if (vstate[i] == V_REL && !voice_active[i]) begin
                    vstate[i] <= V_FREE;
                end else if (vstate[i] == V_STEAL && !voice_active[i]) begin
                    vstate[i] <= V_HELD;
                end
                if (dec_hit && dec_idx == IW'(i) && dec_age_clr)
                    age[i] <= '0;
                else if (ce && age[i] != AGE_MAX)
                    age[i] <= age[i] + AGE_W'(1);
            end
        end
    end

    // trig is decoded straight from state so it drops with the async reset
    always_comb begin
        trig       = '0;
        voice_note = '0;
        for (int i = 0; i < NVOICES; i++) begin
            trig[i]                      = (vstate[i] == V_HELD);
            voice_note[i*NOTE_W +: NOTE_W] = note[i];
        end
    end

`ifdef VOICE_ALLOC_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steal_count      <= '0;
            orphan_off_count <= '0;
        end else begin
            if (dec_steal && steal_count != 16'hFFFF)
                steal_count <= steal_count + 16'd1;
            if (dec_orphan && orphan_off_count != 16'hFFFF)
                orphan_off_count <= orphan_off_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_voice_allocator.sv
// Directed self-checking bench for voice_allocator (NVOICES=4, NOTE_W=7, AGE_W=8).
module tb_voice_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        ev_valid;
    logic        ev_ready;
    logic        ev_on;
    logic [6:0]  ev_note;
    logic [3:0]  voice_active;
    logic [3:0]  trig;
    logic [27:0] voice_note;
    logic        steal;
`ifdef VOICE_ALLOC_STATS_EN
    logic [15:0] steal_count;
    logic [15:0] orphan_off_count;
`endif

    int checks     = 0;
    int failures   = 0;
    int steal_seen = 0;

    voice_allocator #(.NVOICES(4), .NOTE_W(7), .AGE_W(8)) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_on(ev_on), .ev_note(ev_note),
        .voice_active(voice_active), .trig(trig), .voice_note(voice_note), .steal(steal)
`ifdef VOICE_ALLOC_STATS_EN
        , .steal_count(steal_count), .orphan_off_count(orphan_off_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (steal) steal_seen++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] notes(input int n0, input int n1, input int n2, input int n3);
        logic [27:0] v;
        v = {n3[6:0], n2[6:0], n1[6:0], n0[6:0]};
        return {4'b0, v};
    endfunction

    // Presents one event, returns #1 after the edge that starts cycle T+2
    task automatic send(input logic on, input logic [6:0] n);
        int waited = 0;
        @(negedge clk);
        while (!ev_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before", ev_ready, 1);
        ev_valid = 1'b1; ev_on = on; ev_note = n;
        @(posedge clk); #1;
        ev_valid = 1'b0;
        check("ready_t1", ev_ready, 0);
        @(posedge clk); #1;
        check("ready_t2", ev_ready, 1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; voice_active = '0;
        #12;
        check("rst_trig", trig, 0);
        check("rst_notes", voice_note, 0);
        check("rst_steal", steal, 0);
        check("rst_ready", ev_ready, 1);
        @(negedge clk); rst = 1'b0;

        // First note-on lands on voice 0
        send(1'b1, 7'd60);
        check("on60_trig", trig, 4'b0001);
        check("on60_note0", voice_note[6:0], 60);
        check("on60_steal", steal, 0);

        send(1'b1, 7'd62);
        send(1'b1, 7'd64);
        send(1'b1, 7'd65);
        check("four_trig", trig, 4'b1111);
        check("four_notes", voice_note, notes(60, 62, 64, 65));
        voice_active = 4'b1111;

        // Note-off 62: voice 1 releases, stays REL while its envelope runs
        send(1'b0, 7'd62);
        check("off62_trig", trig, 4'b1101);
        cycles(10);
        check("rel_hold_trig", trig, 4'b1101);
        @(negedge clk); voice_active[1] = 1'b0;
        cycles(1);

        // Free voice 0 as well, then refill 0 and 1 so voice 2 becomes oldest
        send(1'b0, 7'd60);
        check("off60_trig", trig, 4'b1100);
        @(negedge clk); voice_active[0] = 1'b0;
        cycles(1);
        send(1'b1, 7'd66);
        check("on66_trig", trig, 4'b1101);
        send(1'b1, 7'd67);
        check("on67_trig", trig, 4'b1111);
        check("refill_notes", voice_note, notes(66, 67, 64, 65));
        check("no_steal_yet", steal_seen, 0);

        // All held: note-on 70 steals oldest voice 2
        send(1'b1, 7'd70);
        check("steal_trig", trig, 4'b1011);
        check("steal_pulse", steal, 1);
        check("steal_note2", voice_note[20:14], 70);
        cycles(1);
        check("steal_pulse_end", steal, 0);
        cycles(4);
        check("steal_wait_trig", trig, 4'b1011);
        @(negedge clk); voice_active[2] = 1'b0;
        #1;
        check("steal_pre_edge", trig, 4'b1011);
        cycles(1);
        check("steal_retrig", trig, 4'b1111);
        check("steal_once", steal_seen, 1);

        // Unmatched note-off is ignored
        send(1'b0, 7'd99);
        check("orphan_trig", trig, 4'b1111);
        check("orphan_notes", voice_note, notes(66, 67, 70, 65));
`ifdef VOICE_ALLOC_STATS_EN
        check("orphan_count", orphan_off_count, 1);
        check("steal_count", steal_count, 1);
`endif

        // Retrigger of a held note: voice 0 goes to STEAL without a steal pulse
        voice_active = 4'b1111;
        send(1'b1, 7'd66);
        check("same_trig", trig, 4'b1110);
        check("same_steal", steal, 0);
        cycles(3);
        check("same_wait", trig, 4'b1110);
        @(negedge clk); voice_active[0] = 1'b0;
        cycles(1);
        check("same_retrig", trig, 4'b1111);
        check("same_note0", voice_note[6:0], 66);
        check("same_no_pulse", steal_seen, 1);

        // Voice 3 into STEAL, then asynchronous reset mid-operation
        send(1'b1, 7'd65);
        check("pre_rst_trig", trig, 4'b0111);
        @(negedge clk); rst = 1'b1;
        #1;
        check("async_rst_trig", trig, 0);
        check("async_rst_ready", ev_ready, 1);
        check("async_rst_notes", voice_note, 0);
        @(negedge clk); rst = 1'b0; voice_active = '0;

        send(1'b1, 7'd48);
        check("post_rst_trig", trig, 4'b0001);
        check("post_rst_notes", voice_note, notes(48, 0, 0, 0));
        check("end_steal_count", steal_seen, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
